// File: rtl/glip_channel_arbiter.sv
// glip_channel_arbiter
// Round-robin arbiter sharing one host-bound GLIP stream between CHANNELS
// on-chip sources. Each grant is sent as a framed burst: one header word
// {4'hA, zeros, channel[3:0], len[7:0]} followed by len payload words.
module glip_channel_arbiter #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int MAX_BURST = 8,
  parameter int LVL_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       ch_enable,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*LVL_W-1:0] in_level,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [3:0]                grant_id
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       grant;
  logic [7:0]       len;
  logic [7:0]       cnt;
  logic [3:0]       rr_ptr;

  logic             pick_found;
  logic [3:0]       pick_id;
  logic [7:0]       pick_len;
  int               scan_idx;
  int               pick_idx;
  int               pick_lvl;

  logic [CH_W-1:0]  gidx;
  logic [WIDTH-1:0] header_word;

  assign gidx = grant[CH_W-1:0];

  // Round-robin scan: first eligible channel after the last one served, and
  // its burst length clipped to MAX_BURST.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = 0;
    scan_idx   = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      scan_idx = (int'(rr_ptr) + k) % CHANNELS;
      if (!pick_found && ch_enable[scan_idx] &&
          (in_level[scan_idx*LVL_W +: LVL_W] != '0)) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
        pick_id    = 4'(scan_idx);
      end
    end
    pick_lvl = int'(in_level[pick_idx*LVL_W +: LVL_W]);
    pick_len = (pick_lvl > MAX_BURST) ? 8'(MAX_BURST) : 8'(pick_lvl);
  end

  // Header word: marker nibble on top, channel and length in the low 12 bits.
  always_comb begin
    header_word                = '0;
    header_word[WIDTH-1 -: 4]  = 4'hA;
    header_word[11:0]          = {grant, len};
  end

  // Burst sequencer: grant in IDLE, emit header, then pass len payload words.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      len    <= '0;
      cnt    <= '0;
      rr_ptr <= 4'(CHANNELS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_id;
            len   <= pick_len;
            state <= HEADER;
          end
        end
        HEADER: begin
          if (out_ready) begin
            cnt   <= len;
            state <= DATA;
          end
        end
        DATA: begin
          if (in_valid[gidx] && out_ready) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              rr_ptr <= grant;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output mux: header from registered state, payload passed straight through
  // from the granted source so stalls propagate in both directions.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    in_ready  = '0;
    case (state)
      HEADER: begin
        out_valid = 1'b1;
        out_data  = header_word;
      end
      DATA: begin
        out_valid      = in_valid[gidx];
        out_data       = in_data[gidx*WIDTH +: WIDTH];
        in_ready[gidx] = out_ready;
      end
      default: ;
    endcase
  end

  assign busy     = (state != IDLE);
  assign grant_id = grant;

endmodule

// File: tb/tb_glip_channel_arbiter.sv
// tb_glip_channel_arbiter
// Sources are queues of words; a burst-level model predicts the whole output
// stream (headers and payload) from the round-robin rules, and a per-cycle
// monitor compares the DUT stream, handshakes and idle gaps against it.
module tb_glip_channel_arbiter;

  localparam int WIDTH = 16;
  localparam int CH    = 4;
  localparam int MAXB  = 8;
  localparam int LVL_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CH-1:0]        ch_enable;
  logic [CH*WIDTH-1:0]  in_data;
  logic [CH-1:0]        in_valid;
  logic [CH-1:0]        in_ready;
  logic [CH*LVL_W-1:0]  in_level;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic [3:0]           grant_id;

  glip_channel_arbiter #(
    .WIDTH(WIDTH), .CHANNELS(CH), .MAX_BURST(MAXB), .LVL_W(LVL_W)
  ) dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_level(in_level),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hdr;
    int          ch;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] src_q[CH][$];
  int          model_rr;
  bit          rnd_ready, rnd_valid;
  bit          hold_pending, gap_due, hdr_due;
  logic [15:0] hold_val;
  logic [CH-1:0] pop_mask;
  int          n_cmp, n_err;

  // Present every source queue to the DUT and pick this cycle's handshakes.
  task automatic drive_sources();
    for (int c = 0; c < CH; c++) begin
      in_data[c*WIDTH +: WIDTH] = (src_q[c].size() > 0) ? src_q[c][0] : 16'h0;
      in_level[c*LVL_W +: LVL_W] = 8'(src_q[c].size());
      in_valid[c] = (src_q[c].size() > 0) && (!rnd_valid || ($urandom_range(3) != 0));
    end
    out_ready = !rnd_ready || ($urandom_range(1) == 1);
  endtask

  // Burst-level model: serve enabled channels round-robin from the word
  // counts currently held, each grant taking min(remaining, MAXB) words.
  task automatic build_expect();
    int rem[CH];
    int pos[CH];
    int found, len, c;
    for (int i = 0; i < CH; i++) begin
      rem[i] = src_q[i].size();
      pos[i] = 0;
    end
    forever begin
      found = -1;
      for (int k = 1; k <= CH; k++) begin
        c = (model_rr + k) % CH;
        if (found < 0 && ch_enable[c] && rem[c] > 0) found = c;
      end
      if (found < 0) break;
      len = (rem[found] > MAXB) ? MAXB : rem[found];
      exp_q.push_back('{1'b1, found, 16'hA000 | 16'(found << 8) | 16'(len)});
      for (int j = 0; j < len; j++)
        exp_q.push_back('{1'b0, found, src_q[found][pos[found] + j]});
      pos[found] += len;
      rem[found] -= len;
      model_rr = found;
    end
  endtask

  task automatic clear_flags();
    hold_pending = 1'b0;
    gap_due      = 1'b0;
    hdr_due      = 1'b0;
  endtask

  // One clock: sample at negedge against the model, then update sources.
  task automatic step();
    exp_t e;
    int   g;
    @(negedge clk);
    pop_mask = in_valid & in_ready;
    if (gap_due) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL idle_gap: out_valid=%b want 0", out_valid);
      end
      gap_due = 1'b0;
      hdr_due = (exp_q.size() > 0);
    end else if (hdr_due) begin
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL header_latency: out_valid=%b want 1", out_valid);
      end
      hdr_due = 1'b0;
    end
    if (exp_q.size() == 0) begin
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== '0) begin
        n_err++; $display("FAIL spurious: out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
      end
    end else begin
      e = exp_q[0];
      if (e.hdr) begin
        n_cmp++;
        if (in_ready !== '0) begin
          n_err++; $display("FAIL hdr_in_ready: got %b want 0000", in_ready);
        end
        if (hold_pending) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_data !== hold_val) begin
            n_err++; $display("FAIL header_hold: valid=%b data=%h want 1/%h", out_valid, out_data, hold_val);
          end
        end
        if (out_valid === 1'b1) begin
          n_cmp++;
          if (out_data !== e.data) begin
            n_err++; $display("FAIL header: got %h want %h", out_data, e.data);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            hold_pending = 1'b0;
          end else begin
            hold_pending = 1'b1;
            hold_val     = e.data;
          end
        end
      end else begin
        g = e.ch;
        n_cmp++;
        if (in_ready !== (4'(out_ready) << g) || out_valid !== in_valid[g] || grant_id !== 4'(g)) begin
          n_err++;
          $display("FAIL data_handshake: in_ready=%b out_valid=%b grant=%0d want %b/%b/%0d",
                   in_ready, out_valid, grant_id, 4'(out_ready) << g, in_valid[g], g);
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          if (out_data !== e.data) begin
            n_err++; $display("FAIL payload ch%0d: got %h want %h", g, out_data, e.data);
          end
          void'(exp_q.pop_front());
          if (exp_q.size() == 0 || exp_q[0].hdr) gap_due = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++)
      if (pop_mask[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
    drive_sources();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL drain_timeout: %0d words left want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) step();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rr = CH - 1;
    exp_q.delete();
    clear_flags();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ch_enable = 4'b0001;
    src_q[0] = '{16'hC001, 16'hC002, 16'hC003};
    drive_sources();
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== '0)    begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (grant_id !== 4'h0)  begin n_err++; $display("FAIL rst_grant: got %h want 0", grant_id); end
    model_rr = CH - 1;
    exp_q.delete();
    clear_flags();
    build_expect();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rel_idle: got %b want 0", out_valid); end
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'hA003 || busy !== 1'b1) begin
        n_err++; $display("FAIL rel_header: valid=%b data=%h busy=%b want 1/a003/1", out_valid, out_data, busy);
      end
    end
    @(posedge clk);
    #1;
    drive_sources();
    drain(50);
  endtask

  task automatic test_single();
    src_q[1] = '{16'h1111, 16'h2222, 16'h3333};
    ch_enable = 4'b0010;
    drive_sources();
    build_expect();
    drain(50);
  endtask

  task automatic test_round_robin();
    pulse_reset();
    ch_enable = 4'b1111;
    for (int c = 0; c < CH; c++)
      src_q[c] = '{16'(16'h0100 * c + 1), 16'(16'h0100 * c + 2)};
    drive_sources();
    build_expect();
    drain(100);
    for (int c = 0; c < CH; c++) src_q[c] = '{16'(16'h5000 + c)};
    drive_sources();
    build_expect();
    drain(100);
  endtask

  task automatic test_long_burst();
    ch_enable = 4'b0100;
    for (int i = 0; i < 20; i++) src_q[2].push_back(16'(16'h2000 + i));
    drive_sources();
    build_expect();
    drain(200);
  endtask

  task automatic test_backpressure();
    rnd_ready = 1'b1;
    rnd_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      ch_enable = 4'($urandom_range(15));
      for (int c = 0; c < CH; c++) begin
        int n = $urandom_range(20);
        for (int i = 0; i < n; i++) src_q[c].push_back(16'($urandom));
      end
      drive_sources();
      build_expect();
      drain(2000);
      ch_enable = 4'b0000;
      for (int c = 0; c < CH; c++) src_q[c].delete();
      drive_sources();
    end
    rnd_ready = 1'b0;
    rnd_valid = 1'b0;
    drive_sources();
    repeat (2) step();
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    ch_enable = 4'b0010;
    src_q[1] = '{16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hD005};
    drive_sources();
    build_expect();
    while (exp_q.size() > 4 && n < 50) begin
      step();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 4) begin n_err++; $display("FAIL mid_wait: left=%0d want 4", exp_q.size()); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== '0 || busy !== 1'b0 || grant_id !== 4'h0 || out_data !== 16'h0) begin
      n_err++;
      $display("FAIL mid_reset: valid=%b ready=%b busy=%b grant=%h data=%h want all 0",
               out_valid, in_ready, busy, grant_id, out_data);
    end
    @(posedge clk);
    #1;
    model_rr = CH - 1;
    exp_q.delete();
    clear_flags();
    build_expect();
    rst = 1'b0;
    drain(50);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rnd_ready = 1'b0;
    rnd_valid = 1'b0;
    in_data = '0;
    in_valid = '0;
    in_level = '0;
    out_ready = 1'b0;
    ch_enable = '0;
    model_rr = CH - 1;
    clear_flags();
    test_reset();
    test_single();
    test_round_robin();
    test_long_burst();
    test_backpressure();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
